prog_clk_divider: RTL and testbench

PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

---
 rtl/prog_clk_divider.sv | 117 +++++++++++
 tb/tb_prog_clk_divider.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider with shadowed period/high-time
// configuration that takes effect only at a period boundary.
module prog_clk_divider #(
    parameter int unsigned NCH = 2,
    parameter int unsigned WIDTH = 32,
    parameter logic [WIDTH-1:0] DEF_DIV = WIDTH'(50000000),
    parameter logic [WIDTH-1:0] DEF_HIGH = DEF_DIV / 2,
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CW-1:0]    cfg_ch,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             cfg_err,
    output logic [NCH-1:0]   clk_div,
    output logic [NCH-1:0]   tick
);

    logic [NCH-1:0] pend_vec;
    logic           ch_ok;
    logic           illegal;
    logic           accept;
    logic           load;

    assign ch_ok = 32'(cfg_ch) < 32'(NCH);

    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (32'(cfg_ch) == 32'(i) && pend_vec[i]) begin
                cfg_ready = 1'b0;
            end
        end
    end

    assign illegal = (cfg_div < WIDTH'(2)) || (cfg_high == '0) ||
                     (cfg_high >= cfg_div) || !ch_ok;
    assign accept = cfg_valid && cfg_ready;
    assign load = accept && !illegal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept && illegal;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] div_q;
        logic [WIDTH-1:0] high_q;
        logic [WIDTH-1:0] div_sh;
        logic [WIDTH-1:0] high_sh;
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] cnt_inc;
        logic             pend;
        logic             run;
        logic             clk_q;
        logic             tick_q;
        logic             start;
        logic             sel;

        assign cnt_inc = cnt + WIDTH'(1);
        // a new period begins either from idle or when the counter wraps
        assign start = !run || (cnt == div_q - WIDTH'(1));
        assign sel = load && (32'(cfg_ch) == 32'(i));
        assign pend_vec[i] = pend;
        assign clk_div[i] = clk_q;
        assign tick[i] = tick_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                div_q   <= DEF_DIV;
                high_q  <= DEF_HIGH;
                div_sh  <= DEF_DIV;
                high_sh <= DEF_HIGH;
                cnt     <= '0;
                pend    <= 1'b0;
                run     <= 1'b0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                if (!en[i]) begin
                    cnt    <= '0;
                    run    <= 1'b0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                end else if (start) begin
                    run    <= 1'b1;
                    cnt    <= '0;
                    clk_q  <= 1'b1;
                    tick_q <= 1'b1;
                    if (pend) begin
                        div_q  <= div_sh;
                        high_q <= high_sh;
                        pend   <= 1'b0;
                    end
                end else begin
                    cnt    <= cnt_inc;
                    clk_q  <= cnt_inc < high_q;
                    tick_q <= 1'b0;
                end
                // only accepted when pend was clear, so never races the apply
                if (sel) begin
                    div_sh  <= cfg_div;
                    high_sh <= cfg_high;
                    pend    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Self-checking bench for prog_clk_divider: vector table, directed corner
// sequences and randomized traffic against a period-position reference model.
module tb_prog_clk_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] en = 2'b00;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [0:0] cfg_ch = 1'b0;
    logic [7:0] cfg_div = 8'd0;
    logic [7:0] cfg_high = 8'd0;
    logic       cfg_err;
    logic [1:0] clk_div;
    logic [1:0] tick;

    int checks = 0;
    int failures = 0;

    int a_div[2], a_high[2], s_div[2], s_high[2], pos[2];
    bit pend[2], run[2];
    logic [1:0] m_clk, m_tick;
    logic m_err;

    typedef struct {
        logic [1:0] en;
        logic       v;
        int         d;
        int         h;
        logic [1:0] ck;
        logic [1:0] tk;
        logic       rdy;
        logic       err;
    } vec_t;

    vec_t tbl[22];

    prog_clk_divider #(
        .NCH(2),
        .WIDTH(8),
        .DEF_DIV(8'd4),
        .DEF_HIGH(8'd2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .cfg_high(cfg_high),
        .cfg_err(cfg_err),
        .clk_div(clk_div),
        .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            a_div[i] = 4;
            a_high[i] = 2;
            s_div[i] = 4;
            s_high[i] = 2;
            pos[i] = 0;
            pend[i] = 0;
            run[i] = 0;
        end
        m_clk = 2'b00;
        m_tick = 2'b00;
        m_err = 1'b0;
    endtask

    // one clock: drive, check ready, step model, clock, compare outputs
    task automatic cycle(input logic [1:0] e, input logic v, input int ch,
                         input int d, input int h, output logic rdy_pre);
        bit acc, legal;
        en = e;
        cfg_valid = v;
        cfg_ch = 1'(ch);
        cfg_div = 8'(d);
        cfg_high = 8'(h);
        #1;
        rdy_pre = cfg_ready;
        chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, !pend[ch]});
        acc = v && !pend[ch];
        legal = (d >= 2) && (h >= 1) && (h < d);
        m_err = acc && !legal;
        for (int i = 0; i < 2; i++) begin
            if (!e[i]) begin
                run[i] = 0;
                pos[i] = 0;
            end else if (!run[i] || pos[i] == a_div[i] - 1) begin
                if (pend[i]) begin
                    a_div[i] = s_div[i];
                    a_high[i] = s_high[i];
                    pend[i] = 0;
                end
                run[i] = 1;
                pos[i] = 0;
            end else begin
                pos[i] = pos[i] + 1;
            end
            m_clk[i] = e[i] && (pos[i] < a_high[i]);
            m_tick[i] = e[i] && (pos[i] == 0);
            if (acc && legal && ch == i) begin
                s_div[i] = d;
                s_high[i] = h;
                pend[i] = 1;
            end
        end
        @(posedge clk);
        #1;
        chk("clk_div", {30'd0, clk_div}, {30'd0, m_clk});
        chk("tick", {30'd0, tick}, {30'd0, m_tick});
        chk("cfg_err", {31'd0, cfg_err}, {31'd0, m_err});
    endtask

    task automatic idle(input logic [1:0] e);
        logic r;
        cycle(e, 1'b0, 0, 0, 0, r);
    endtask

    initial begin
        logic r;
        logic [1:0] e;

        tbl[0]  = '{2'b01, 1'b0, 0, 0, 2'b01, 2'b01, 1'b1, 1'b0};
        tbl[1]  = '{2'b01, 1'b0, 0, 0, 2'b01, 2'b00, 1'b1, 1'b0};
        tbl[2]  = '{2'b01, 1'b0, 0, 0, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[3]  = '{2'b01, 1'b0, 0, 0, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[4]  = '{2'b01, 1'b0, 0, 0, 2'b01, 2'b01, 1'b1, 1'b0};
        tbl[5]  = '{2'b01, 1'b0, 0, 0, 2'b01, 2'b00, 1'b1, 1'b0};
        tbl[6]  = '{2'b01, 1'b0, 0, 0, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[7]  = '{2'b01, 1'b0, 0, 0, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[8]  = '{2'b01, 1'b1, 1, 1, 2'b01, 2'b01, 1'b1, 1'b1};
        tbl[9]  = '{2'b01, 1'b1, 5, 0, 2'b01, 2'b00, 1'b1, 1'b1};
        tbl[10] = '{2'b01, 1'b1, 3, 3, 2'b00, 2'b00, 1'b1, 1'b1};
        tbl[11] = '{2'b01, 1'b0, 0, 0, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[12] = '{2'b01, 1'b0, 0, 0, 2'b01, 2'b01, 1'b1, 1'b0};
        tbl[13] = '{2'b01, 1'b1, 5, 2, 2'b01, 2'b00, 1'b1, 1'b0};
        tbl[14] = '{2'b01, 1'b0, 0, 0, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[15] = '{2'b01, 1'b0, 0, 0, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[16] = '{2'b01, 1'b0, 0, 0, 2'b01, 2'b01, 1'b0, 1'b0};
        tbl[17] = '{2'b01, 1'b0, 0, 0, 2'b01, 2'b00, 1'b1, 1'b0};
        tbl[18] = '{2'b01, 1'b0, 0, 0, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[19] = '{2'b01, 1'b0, 0, 0, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[20] = '{2'b01, 1'b0, 0, 0, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[21] = '{2'b01, 1'b0, 0, 0, 2'b01, 2'b01, 1'b1, 1'b0};

        m_reset();
        #1;
        chk("rst_clk_div", {30'd0, clk_div}, 32'd0);
        chk("rst_tick", {30'd0, tick}, 32'd0);
        chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // default waveform, illegal writes, mid-period reconfiguration
        for (int k = 0; k < 22; k++) begin
            cycle(tbl[k].en, tbl[k].v, 0, tbl[k].d, tbl[k].h, r);
            chk($sformatf("tbl%0d_ready", k), {31'd0, r}, {31'd0, tbl[k].rdy});
            chk($sformatf("tbl%0d_clk", k), {30'd0, clk_div}, {30'd0, tbl[k].ck});
            chk($sformatf("tbl%0d_tick", k), {30'd0, tick}, {30'd0, tbl[k].tk});
            chk($sformatf("tbl%0d_err", k), {31'd0, cfg_err}, {31'd0, tbl[k].err});
        end

        // enable drop during high phase, then restart a full period
        idle(2'b01);
        idle(2'b00);
        chk("drop_clk", {30'd0, clk_div}, 32'd0);
        chk("drop_tick", {30'd0, tick}, 32'd0);
        idle(2'b01);
        chk("restart_clk", {30'd0, clk_div}, 32'd1);
        chk("restart_tick", {30'd0, tick}, 32'd1);
        for (int k = 1; k <= 5; k++) begin
            idle(2'b01);
            chk("restart_pat", {31'd0, clk_div[0]}, {31'd0, (k % 5) < 2});
        end

        // two independent channels with different odd periods
        cycle(2'b00, 1'b1, 0, 3, 1, r);
        cycle(2'b00, 1'b1, 1, 7, 6, r);
        for (int k = 0; k < 21; k++) begin
            idle(2'b11);
            chk("ch0_pat", {31'd0, clk_div[0]}, {31'd0, (k % 3) == 0});
            chk("ch1_pat", {31'd0, clk_div[1]}, {31'd0, (k % 7) < 6});
            chk("ch1_tick", {31'd0, tick[1]}, {31'd0, (k % 7) == 0});
        end

        // randomized traffic against the model
        e = 2'b11;
        for (int k = 0; k < 400; k++) begin
            int d;
            if ($urandom_range(0, 19) == 0) e[0] = ~e[0];
            if ($urandom_range(0, 19) == 0) e[1] = ~e[1];
            d = $urandom_range(0, 12);
            cycle(e, 1'($urandom_range(0, 2) == 0), $urandom_range(0, 1), d,
                  $urandom_range(0, d + 1), r);
        end

        // asynchronous reset mid-period drops outputs and restores defaults
        idle(2'b11);
        idle(2'b11);
        cfg_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_clk", {30'd0, clk_div}, 32'd0);
        chk("arst_tick", {30'd0, tick}, 32'd0);
        chk("arst_ready", {31'd0, cfg_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("arst_hold", {30'd0, clk_div}, 32'd0);
        rst = 1'b1;
        m_reset();
        for (int k = 0; k < 8; k++) begin
            idle(2'b11);
            chk("post_rst_pat", {30'd0, clk_div},
                ((k % 4) < 2) ? 32'd3 : 32'd0);
            chk("post_rst_tick", {30'd0, tick},
                ((k % 4) == 0) ? 32'd3 : 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
